// File: rtl/ibex_rf_arb_pkg.sv
// ibex_rf_arb_pkg: shared types and helpers for the register-file writeback arbiter
package ibex_rf_arb_pkg;

    localparam int unsigned RegAddrW = 5;

    typedef enum logic {
        SEL_ALU = 1'b0,
        SEL_LSU = 1'b1
    } arb_sel_e;

    typedef struct packed {
        logic [RegAddrW-1:0] addr;
        logic [31:0]         data;
    } rf_wr_req_t;

    // RV32E only implements x0..x15, so any address with bit 4 set is illegal there
    function automatic logic rf_addr_legal(input logic [RegAddrW-1:0] addr, input logic rv32e);
        return !(rv32e && addr[4]);
    endfunction

endpackage

// File: rtl/rf_rr_arb2.sv
// rf_rr_arb2: two-way round-robin arbiter
//   clk_i, rst_ni : clock, async active-low reset
//   req_i[1:0]    : requests, indexed by arb_sel_e
//   gnt_o[1:0]    : one-hot grant (zero when nobody requests)
//   contested_o   : both requesters active this cycle
module rf_rr_arb2
    import ibex_rf_arb_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o,
    output logic       contested_o
);

    arb_sel_e rr_ptr_q, rr_ptr_d;

    // The pointer names the winner of the next contested cycle and only moves on contention
    always_comb begin
        contested_o = &req_i;
        gnt_o       = contested_o ? (rr_ptr_q == SEL_LSU ? 2'b10 : 2'b01) : req_i;
        rr_ptr_d    = contested_o ? (rr_ptr_q == SEL_LSU ? SEL_ALU : SEL_LSU) : rr_ptr_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) rr_ptr_q <= SEL_LSU;
        else         rr_ptr_q <= rr_ptr_d;
    end

endmodule

// File: rtl/ibex_rf_wb_arbiter.sv
// ibex_rf_wb_arbiter: shares RF write port W1 between ALU and LSU writeback
//   alu_*/lsu_*         : req/addr/data held until the combinational gnt
//   raddr_a/b_i         : read addresses checked for pending or in-flight writes
//   hazard_a/b_o        : raise so ID can stall
//   we/waddr/wdata_a_o  : registered W1 write, one cycle after grant
//   err_o               : pulse when the granted write had an illegal address
//   cnt_clr_i           : sync clear of conflict_cnt_o (saturating contention count)
module ibex_rf_wb_arbiter
    import ibex_rf_arb_pkg::*;
#(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned RV32E     = 0,
    parameter int unsigned CntWidth  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 alu_req_i,
    input  logic [4:0]           alu_addr_i,
    input  logic [DataWidth-1:0] alu_data_i,
    output logic                 alu_gnt_o,
    input  logic                 lsu_req_i,
    input  logic [4:0]           lsu_addr_i,
    input  logic [DataWidth-1:0] lsu_data_i,
    output logic                 lsu_gnt_o,
    input  logic [4:0]           raddr_a_i,
    input  logic [4:0]           raddr_b_i,
    output logic                 hazard_a_o,
    output logic                 hazard_b_o,
    output logic                 we_a_o,
    output logic [4:0]           waddr_a_o,
    output logic [DataWidth-1:0] wdata_a_o,
    output logic                 err_o,
    input  logic                 cnt_clr_i,
    output logic [CntWidth-1:0]  conflict_cnt_o
);

    logic [1:0]           gnt;
    logic                 contested, g_any, g_legal, alu_vis, lsu_vis;
    logic [4:0]           g_addr;
    logic [DataWidth-1:0] g_data;
    logic                 we_q, we_d, err_q, err_d;
    logic [4:0]           waddr_q, waddr_d;
    logic [DataWidth-1:0] wdata_q, wdata_d;
    logic [CntWidth-1:0]  cnt_q, cnt_d;

    rf_rr_arb2 u_arb (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_i       ({lsu_req_i, alu_req_i}),
        .gnt_o       (gnt),
        .contested_o (contested)
    );

    assign alu_gnt_o = gnt[SEL_ALU];
    assign lsu_gnt_o = gnt[SEL_LSU];

    always_comb begin
        g_any   = |gnt;
        g_addr  = gnt[SEL_LSU] ? lsu_addr_i : alu_addr_i;
        g_data  = gnt[SEL_LSU] ? lsu_data_i : alu_data_i;
        g_legal = rf_addr_legal(g_addr, RV32E != 0);
        // x0 writes are accepted but never reach the RF, and they are not errors
        we_d    = g_any && g_legal && g_addr != '0;
        err_d   = g_any && !g_legal;
        waddr_d = g_any ? g_addr : waddr_q;
        wdata_d = g_any ? g_data : wdata_q;
        cnt_d   = cnt_clr_i ? '0 : (contested && cnt_q != '1) ? cnt_q + CntWidth'(1) : cnt_q;
        // Illegal destinations will be dropped, so they never create a hazard
        alu_vis = alu_req_i && rf_addr_legal(alu_addr_i, RV32E != 0);
        lsu_vis = lsu_req_i && rf_addr_legal(lsu_addr_i, RV32E != 0);
        hazard_a_o = raddr_a_i != '0 && ((we_q && waddr_q == raddr_a_i) ||
                     (alu_vis && alu_addr_i == raddr_a_i) || (lsu_vis && lsu_addr_i == raddr_a_i));
        hazard_b_o = raddr_b_i != '0 && ((we_q && waddr_q == raddr_b_i) ||
                     (alu_vis && alu_addr_i == raddr_b_i) || (lsu_vis && lsu_addr_i == raddr_b_i));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            we_q    <= we_d;
            err_q   <= err_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
        end
    end

    assign we_a_o         = we_q;
    assign err_o          = err_q;
    assign waddr_a_o      = waddr_q;
    assign wdata_a_o      = wdata_q;
    assign conflict_cnt_o = cnt_q;

endmodule

// File: tb/tb_ibex_rf_wb_arbiter.sv
// tb_ibex_rf_wb_arbiter: directed and random checks of the writeback arbiter against a reference model
module tb_ibex_rf_wb_arbiter;

    localparam int CW   = 8;
    localparam int CMAX = 255;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          alu_req_i = 1'b0, lsu_req_i = 1'b0, cnt_clr_i = 1'b0;
    logic [4:0]    alu_addr_i = '0, lsu_addr_i = '0, raddr_a_i = '0, raddr_b_i = '0;
    logic [31:0]   alu_data_i = '0, lsu_data_i = '0;
    logic          alu_gnt_o, lsu_gnt_o, hazard_a_o, hazard_b_o, we_a_o, err_o;
    logic [4:0]    waddr_a_o;
    logic [31:0]   wdata_a_o;
    logic [CW-1:0] conflict_cnt_o;

    ibex_rf_wb_arbiter #(.DataWidth(32), .RV32E(1), .CntWidth(CW)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .alu_req_i      (alu_req_i),
        .alu_addr_i     (alu_addr_i),
        .alu_data_i     (alu_data_i),
        .alu_gnt_o      (alu_gnt_o),
        .lsu_req_i      (lsu_req_i),
        .lsu_addr_i     (lsu_addr_i),
        .lsu_data_i     (lsu_data_i),
        .lsu_gnt_o      (lsu_gnt_o),
        .raddr_a_i      (raddr_a_i),
        .raddr_b_i      (raddr_b_i),
        .hazard_a_o     (hazard_a_o),
        .hazard_b_o     (hazard_b_o),
        .we_a_o         (we_a_o),
        .waddr_a_o      (waddr_a_o),
        .wdata_a_o      (wdata_a_o),
        .err_o          (err_o),
        .cnt_clr_i      (cnt_clr_i),
        .conflict_cnt_o (conflict_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int n_chk = 0, n_fail = 0;

    // Reference model: who wins the next tie, what W1 shows next cycle, and the count
    bit          pref_lsu;
    bit          e_we, e_err, e_valid;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata;
    int          e_cnt, alu_wait, lsu_wait;
    bit          g_alu, g_lsu, o_hza, o_hzb;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit legal(input logic [4:0] a);
        return a < 16;
    endfunction

    function automatic bit hz(input logic [4:0] r);
        return r != 0 && ((e_we && e_waddr == r) ||
               (alu_req_i && alu_addr_i == r && legal(alu_addr_i)) ||
               (lsu_req_i && lsu_addr_i == r && legal(lsu_addr_i)));
    endfunction

    task automatic issue_alu(input logic [4:0] a, input logic [31:0] d);
        alu_req_i = 1'b1; alu_addr_i = a; alu_data_i = d;
    endtask

    task automatic issue_lsu(input logic [4:0] a, input logic [31:0] d);
        lsu_req_i = 1'b1; lsu_addr_i = a; lsu_data_i = d;
    endtask

    // One clock: check the DUT at the falling edge, advance the model, drop granted requests
    task automatic step();
        bit ga, gl;
        logic [4:0]  a;
        logic [31:0] d;
        @(negedge clk_i);
        ga = alu_req_i && (!lsu_req_i || !pref_lsu);
        gl = lsu_req_i && (!alu_req_i || pref_lsu);
        chk("alu_gnt", alu_gnt_o, ga);
        chk("lsu_gnt", lsu_gnt_o, gl);
        chk("hazard_a", hazard_a_o, hz(raddr_a_i));
        chk("hazard_b", hazard_b_o, hz(raddr_b_i));
        chk("we", we_a_o, e_we);
        chk("err", err_o, e_err);
        chk("cnt", conflict_cnt_o, e_cnt);
        if (e_valid) begin
            chk("waddr", waddr_a_o, e_waddr);
            chk("wdata", wdata_a_o, e_wdata);
        end
        if (ga) begin chk("alu_wait", alu_wait <= 1, 1); alu_wait = 0; end
        else if (alu_req_i) alu_wait++;
        if (gl) begin chk("lsu_wait", lsu_wait <= 1, 1); lsu_wait = 0; end
        else if (lsu_req_i) lsu_wait++;
        g_alu = alu_gnt_o; g_lsu = lsu_gnt_o; o_hza = hazard_a_o; o_hzb = hazard_b_o;
        a = gl ? lsu_addr_i : alu_addr_i;
        d = gl ? lsu_data_i : alu_data_i;
        e_valid = ga || gl;
        e_we    = e_valid && legal(a) && a != 0;
        e_err   = e_valid && !legal(a);
        if (e_valid) begin e_waddr = a; e_wdata = d; end
        e_cnt = cnt_clr_i ? 0 : (alu_req_i && lsu_req_i) ? (e_cnt < CMAX ? e_cnt + 1 : CMAX) : e_cnt;
        if (alu_req_i && lsu_req_i) pref_lsu = !pref_lsu;
        @(posedge clk_i);
        #1;
        if (ga) alu_req_i = 1'b0;
        if (gl) lsu_req_i = 1'b0;
        cnt_clr_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        alu_req_i = 1'b0; lsu_req_i = 1'b0; cnt_clr_i = 1'b0; raddr_a_i = '0; raddr_b_i = '0;
        pref_lsu = 1'b1; e_we = 0; e_err = 0; e_valid = 0; e_waddr = '0; e_wdata = '0;
        e_cnt = 0; alu_wait = 0; lsu_wait = 0;
        repeat (2) @(posedge clk_i);
        #3 rst_ni = 1'b1;
        chk("rst_we", we_a_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_waddr", waddr_a_o, 0);
        chk("rst_wdata", wdata_a_o, 0);
        chk("rst_cnt", conflict_cnt_o, 0);
        chk("rst_gnt", {alu_gnt_o, lsu_gnt_o}, 0);
    endtask

    // Requesters must hold req/addr/data until granted
    assert property (@(posedge clk_i) disable iff (!rst_ni)
        (alu_req_i && !alu_gnt_o) |=> (alu_req_i && $stable(alu_addr_i) && $stable(alu_data_i)))
        else begin n_fail++; $display("FAIL alu_protocol: request changed before grant"); end
    assert property (@(posedge clk_i) disable iff (!rst_ni)
        (lsu_req_i && !lsu_gnt_o) |=> (lsu_req_i && $stable(lsu_addr_i) && $stable(lsu_data_i)))
        else begin n_fail++; $display("FAIL lsu_protocol: request changed before grant"); end

    initial begin
        int na, nl, k;
        // single ALU write
        do_reset();
        issue_alu(5'd5, 32'hA5A5_0001);
        step();
        chk("t1_gnt", g_alu, 1);
        chk("t1_we", we_a_o, 1);
        chk("t1_waddr", waddr_a_o, 5);
        chk("t1_wdata", wdata_a_o, 32'hA5A5_0001);
        step();
        // first contested cycle goes to LSU
        do_reset();
        issue_alu(5'd3, 32'h0000_0003);
        issue_lsu(5'd4, 32'h0000_0004);
        step();
        chk("t2_first_lsu", g_lsu, 1);
        chk("t2_waddr0", waddr_a_o, 4);
        step();
        chk("t2_second_alu", g_alu, 1);
        chk("t2_waddr1", waddr_a_o, 3);
        step();
        chk("t2_cnt", conflict_cnt_o, 1);
        // two back-to-back streams of eight
        do_reset();
        na = 0; nl = 0; k = 0;
        for (int i = 0; i < 40 && !(na == 8 && nl == 8 && !alu_req_i && !lsu_req_i); i++) begin
            if (!alu_req_i && na < 8) begin issue_alu(5'(na + 1), $urandom); na++; end
            if (!lsu_req_i && nl < 8) begin issue_lsu(5'(nl + 9), $urandom); nl++; end
            step();
            if (g_alu || g_lsu) begin chk("t3_alt", g_lsu, k % 2 == 0); k++; end
        end
        chk("t3_grants", k, 16);
        chk("t3_cnt", conflict_cnt_o, 15);
        step();
        // illegal RV32E destination and x0 write
        do_reset();
        issue_lsu(5'd17, 32'hDEAD_0011);
        step();
        chk("t4_gnt", g_lsu, 1);
        chk("t4_err", err_o, 1);
        chk("t4_we", we_a_o, 0);
        step();
        chk("t4_err_pulse", err_o, 0);
        issue_alu(5'd0, 32'h1234_5678);
        step();
        chk("t4_x0_gnt", g_alu, 1);
        chk("t4_x0_we", we_a_o, 0);
        chk("t4_x0_err", err_o, 0);
        step();
        // hazards: pending, in flight, then clear
        do_reset();
        raddr_a_i = 5'd7; raddr_b_i = 5'd0;
        issue_alu(5'd7, 32'h7777_7777);
        issue_lsu(5'd0, 32'h0);
        step();
        chk("t5_hz_pending", o_hza, 1);
        chk("t5_hzb_x0", o_hzb, 0);
        step();
        chk("t5_hz_granted", o_hza, 1);
        step();
        chk("t5_hz_inflight", o_hza, 1);
        step();
        chk("t5_hz_clear", o_hza, 0);
        // saturation, clear with contention, async reset with a write in flight
        do_reset();
        for (int i = 0; i < 300; i++) begin
            if (!alu_req_i) issue_alu(5'($urandom_range(1, 15)), $urandom);
            if (!lsu_req_i) issue_lsu(5'($urandom_range(1, 15)), $urandom);
            step();
        end
        chk("t6_sat", conflict_cnt_o, CMAX);
        if (!alu_req_i) issue_alu(5'd9, $urandom);
        if (!lsu_req_i) issue_lsu(5'd10, $urandom);
        cnt_clr_i = 1'b1;
        step();
        chk("t6_clr", conflict_cnt_o, 0);
        chk("t6_we_before_rst", we_a_o, 1);
        #2 rst_ni = 1'b0;
        #1;
        chk("t6_we_async", we_a_o, 0);
        chk("t6_waddr_async", waddr_a_o, 0);
        // random traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (!alu_req_i && $urandom_range(0, 2) != 0) issue_alu(5'($urandom_range(0, 31)), $urandom);
            if (!lsu_req_i && $urandom_range(0, 2) != 0) issue_lsu(5'($urandom_range(0, 31)), $urandom);
            case ($urandom_range(0, 3))
                0: raddr_a_i = alu_addr_i;
                1: raddr_a_i = lsu_addr_i;
                2: raddr_a_i = e_waddr;
                default: raddr_a_i = 5'($urandom_range(0, 31));
            endcase
            raddr_b_i = $urandom_range(0, 1) != 0 ? e_waddr : 5'($urandom_range(0, 31));
            cnt_clr_i = $urandom_range(0, 49) == 0;
            step();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ibex_rf_wb_arbiter.md
Name: ibex_rf_wb_arbiter

Overview:
- Shares the register file's single write port W1 between two writeback requesters: ALU/EX and LSU.
- Round-robin arbitration. Granted write is registered and driven onto W1 one cycle later.
- Flags read-after-write hazards on read ports R1/R2 so the ID stage can stall.
- Rejects illegal RV32E destinations and counts contention cycles for performance monitoring.

Parameters:
- DataWidth, 32, width of write data.
- RV32E, 0, when 1 only x0..x15 are legal destinations.
- CntWidth, 16, width of the saturating contention counter.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- alu_req_i  in  1  ALU writeback request, held until granted
- alu_addr_i  in  5  ALU destination register
- alu_data_i  in  DataWidth  ALU write data
- alu_gnt_o  out  1  ALU request accepted this cycle (combinational)
- lsu_req_i  in  1  LSU writeback request, held until granted
- lsu_addr_i  in  5  LSU destination register
- lsu_data_i  in  DataWidth  LSU write data
- lsu_gnt_o  out  1  LSU request accepted this cycle (combinational)
- raddr_a_i  in  5  R1 read address, for hazard check
- raddr_b_i  in  5  R2 read address, for hazard check
- hazard_a_o  out  1  R1 address has a write pending or in flight
- hazard_b_o  out  1  R2 address has a write pending or in flight
- we_a_o  out  1  RF write enable
- waddr_a_o  out  5  RF write address
- wdata_a_o  out  DataWidth  RF write data
- err_o  out  1  one-cycle pulse: granted write had an illegal address
- cnt_clr_i  in  1  synchronous clear of the contention counter
- conflict_cnt_o  out  CntWidth  cycles in which both requesters were active

Behaviour:
- Reset (async, rst_ni=0):
  - we_a_o=0, waddr_a_o=0, wdata_a_o=0, err_o=0, conflict_cnt_o=0.
  - rr_ptr_q=LSU, i.e. LSU is preferred on the first contested cycle.
  - Grant and hazard outputs are combinational; they are 0 only while no request is present.
- Handshake:
  - Requester asserts req with addr/data and holds all three stable until gnt.
  - Transfer completes in the cycle req&gnt=1.
  - Dropping req or changing addr/data before grant is a protocol violation (bench assertion).
- Arbitration:
  - At most one grant per cycle.
  - Single requester: granted immediately.
  - Both requesting: grant the requester selected by rr_ptr_q, then set rr_ptr_q to the other requester.
  - Uncontested grants leave rr_ptr_q unchanged.
  - Worst-case wait is 1 cycle.
- Write stage, latency 1 (granted in cycle N, visible on W1 in cycle N+1):
  - Always captured: waddr_a_o and wdata_a_o.
  - we_a_o=1 only if the address is legal and nonzero.
  - x0 writes are granted and silently dropped: we_a_o=0, err_o=0.
  - Illegal address (RV32E=1 and addr[4]=1): write dropped, err_o=1 for that one cycle.
  - No grant in cycle N: we_a_o=0 in N+1.
- Same destination from both requesters in one cycle: no merging. Writes reach W1 in grant order on consecutive cycles; the last write wins.
- Hazard, evaluated per read port independently. hazard_x_o=1 iff raddr!=0 and any of:
  - we_a_o=1 and waddr_a_o==raddr;
  - alu_req_i=1, alu_addr_i==raddr and the address is legal;
  - lsu_req_i=1, lsu_addr_i==raddr and the address is legal.
- Contention counter:
  - Increments in every cycle where alu_req_i&lsu_req_i=1.
  - Saturates at all-ones with no wrap.
  - cnt_clr_i loads 0; clear has priority over increment.
- Reset mid-operation: the in-flight write is discarded (we_a_o=0 immediately, asynchronously) and pending requests must be re-presented.

Decomposition:
- Package ibex_rf_arb_pkg holds:
  - arb_sel_e {SEL_ALU=1'b0, SEL_LSU=1'b1};
  - struct rf_wr_req_t {addr[4:0], data};
  - localparam RegAddrW=5;
  - function rf_addr_legal(addr, rv32e).
- Sub-module rf_rr_arb2: two-way round-robin arbiter holding rr_ptr_q. Inputs: req vector. Outputs: one-hot gnt vector and a contested flag.

Test Plan:
- Reset release, then ALU req addr=5 data=0xA5A5_0001 only -> alu_gnt_o=1 same cycle; next cycle we_a_o=1, waddr_a_o=5, wdata_a_o=0xA5A5_0001.
- ALU(addr=3) and LSU(addr=4) both held for 3 cycles from reset -> grant order LSU, ALU. W1 writes x4 then x3 on consecutive cycles. Counter=1, since req overlap lasts one cycle.
- Both requesters issue back-to-back streams of 8 writes -> grants strictly alternate. Neither waits more than 1 cycle. conflict_cnt_o=15.
- RV32E=1, LSU addr=17 -> granted; next cycle we_a_o=0, err_o=1 for exactly one cycle. ALU addr=0 -> granted, we_a_o=0, err_o=0.
- raddr_a_i=7 while ALU req addr=7 is pending, then in flight -> hazard_a_o=1 for both cycles, 0 afterwards. raddr_b_i=0 with an x0 request -> hazard_b_o=0.
- Counter driven to 0xFFFF with continuous contention -> holds at 0xFFFF. cnt_clr_i=1 together with contention -> 0. Assert rst_ni=0 while we_a_o=1 -> we_a_o drops immediately.
